// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch front end.
//   fetch_state_e  - controller states
//   LINE_BYTES, LINE_BEATS, WORDS_PER_LINE - cache line geometry
//   line_addr()    - clears the byte-in-line offset of an address
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    EMIT = 2'd3
  } fetch_state_e;

  localparam int unsigned LINE_BYTES     = 64;
  localparam int unsigned LINE_BEATS     = 8;
  localparam int unsigned WORDS_PER_LINE = 16;

  function automatic logic [63:0] line_addr(input logic [63:0] a);
    return a & ~64'(LINE_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// fetch_line_buf: one cache line (512 bits) of instruction storage.
//   clk      in   clock
//   we_i     in   write the beat selected by beat_i
//   beat_i   in   beat index 0..7, beat k occupies line[64k +: 64]
//   wdata_i  in   64-bit beat data
//   word_i   in   32-bit word index 0..15 (little-endian within each beat)
//   rdata_o  out  selected word, combinational
module fetch_line_buf
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        we_i,
  input  logic [2:0]  beat_i,
  input  logic [63:0] wdata_i,
  input  logic [3:0]  word_i,
  output logic [31:0] rdata_o
);

  logic [63:0] beat_q [LINE_BEATS];
  logic [63:0] beat_sel;

  always_ff @(posedge clk) begin
    if (we_i) begin
      beat_q[beat_i] <= wdata_i;
    end
  end

  // Even words live in the low half of a beat, odd words in the high half.
  assign beat_sel = beat_q[word_i[3:1]];
  assign rdata_o  = word_i[0] ? beat_sel[63:32] : beat_sel[31:0];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end ahead of the direct-mapped cache.
// Requests 64-byte lines, collects the 8-beat burst into a line buffer and
// hands 32-bit instructions to decode over valid/ready. Redirects may arrive
// in any state; a burst already in flight is drained without being stored.
//   clk, reset              clock, synchronous active-high reset
//   entry                   start PC, sampled while reset is high
//   bus_reqcyc/reqack       line request handshake
//   bus_req, bus_reqtag     line-aligned request address, constant tag
//   bus_respcyc/respack     response beat handshake (respack combinational)
//   bus_resp, bus_resptag   beat data, tag (ignored)
//   inst_valid/inst_ready   instruction handshake to decode
//   inst, inst_pc           instruction word and its address
//   redirect_valid/_pc      PC redirect, low two bits of the target ignored
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned              BUS_DATA_WIDTH = 64,
  parameter int unsigned              BUS_TAG_WIDTH  = 13,
  parameter logic [BUS_TAG_WIDTH-1:0] FETCH_TAG      = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [BUS_DATA_WIDTH-1:0] entry,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      inst_valid,
  input  logic                      inst_ready,
  output logic [31:0]               inst,
  output logic [BUS_DATA_WIDTH-1:0] inst_pc,
  input  logic                      redirect_valid,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc
);

  fetch_state_e              state_q, state_d;
  logic [BUS_DATA_WIDTH-1:0] pc_q, pc_d;
  logic [BUS_DATA_WIDTH-1:0] req_q, req_d;
  logic [2:0]                cnt_q, cnt_d;
  logic                      stale_q, stale_d;

  logic        beat_fire;
  logic        last_beat;
  logic [31:0] word_rd;
  logic        unused_bits;

  assign unused_bits = ^{bus_resptag, redirect_pc[1:0], entry[1:0]};

  assign beat_fire = (state_q == RECV) && bus_respcyc;
  assign last_beat = beat_fire && (cnt_q == 3'(LINE_BEATS - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A redirect before the ack cannot withdraw the request, so the
        // returning burst is marked stale instead.
        if (redirect_valid) stale_d = 1'b1;
        if (bus_reqack)     state_d = RECV;
      end
      RECV: begin
        if (redirect_valid) stale_d = 1'b1;
        if (beat_fire)      cnt_d   = cnt_q + 3'd1;
        if (last_beat) begin
          stale_d = 1'b0;
          state_d = (stale_q || redirect_valid) ? REQ : EMIT;
        end
      end
      EMIT: begin
        if (redirect_valid) begin
          state_d = REQ;
        end else if (inst_ready) begin
          pc_d = pc_q + BUS_DATA_WIDTH'(4);
          if (pc_q[5:2] == 4'(WORDS_PER_LINE - 1)) state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
    // Redirect overrides any increment; a same-cycle accept is discarded.
    if (redirect_valid) pc_d = {redirect_pc[BUS_DATA_WIDTH-1:2], 2'b00};
  end

  // The request address is captured on entry to REQ so that a later redirect
  // does not disturb a request the cache has not yet acknowledged.
  always_comb begin
    req_d = req_q;
    if ((state_d == REQ) && (state_q != REQ)) req_d = line_addr(pc_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= {entry[BUS_DATA_WIDTH-1:2], 2'b00};
      req_q   <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
    end
  end

  fetch_line_buf u_line_buf (
    .clk     (clk),
    .we_i    (beat_fire && !stale_q),
    .beat_i  (cnt_q),
    .wdata_i (bus_resp),
    .word_i  (pc_q[5:2]),
    .rdata_o (word_rd)
  );

  assign bus_reqcyc  = (state_q == REQ);
  assign bus_req     = bus_reqcyc ? req_q : '0;
  assign bus_reqtag  = FETCH_TAG;
  assign bus_respack = beat_fire;
  assign inst_valid  = (state_q == EMIT);
  assign inst        = inst_valid ? word_rd : '0;
  assign inst_pc     = inst_valid ? pc_q : '0;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] entry;
  logic        bus_reqcyc, bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc, bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_unit #(
    .BUS_DATA_WIDTH (64),
    .BUS_TAG_WIDTH  (13),
    .FETCH_TAG      (13'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .entry          (entry),
    .bus_reqcyc     (bus_reqcyc),
    .bus_reqack     (bus_reqack),
    .bus_req        (bus_req),
    .bus_reqtag     (bus_reqtag),
    .bus_respcyc    (bus_respcyc),
    .bus_respack    (bus_respack),
    .bus_resp       (bus_resp),
    .bus_resptag    (bus_resptag),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  int checks   = 0;
  int failures = 0;
  int unsigned cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Memory image: line 0x1000 holds word i = i, so beat k = {2k+1, 2k};
  // other lines carry their line number in the upper bits.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [23:0] ln;
    ln = a[29:6] - 24'h40;
    return {ln, 4'h0, a[5:2]};
  endfunction

  function automatic logic [63:0] beat_data(input logic [63:0] line, input int k);
    logic [63:0] a;
    a = line + 64'(8 * k);
    return {mem_word(a + 64'd4), mem_word(a)};
  endfunction

  // Architectural model: the PC decode should see next, and the log of
  // instructions decode actually took.
  logic [63:0] mpc;
  logic        in_burst = 1'b0;
  logic [63:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  int unsigned acc_cyc[$];

  always @(negedge clk) begin
    if (reset) begin
      mpc = {entry[63:2], 2'b00};
    end else begin
      check("reqtag", 64'(bus_reqtag), 64'h0);
      check("respack", 64'(bus_respack), 64'(bus_respcyc && in_burst));
      if (in_burst) check("valid_during_burst", 64'(inst_valid), 64'h0);
      if (inst_valid) begin
        check("inst_pc", inst_pc, mpc);
        check("inst", 64'(inst), 64'(mem_word(mpc)));
      end
      if (redirect_valid) begin
        mpc = {redirect_pc[63:2], 2'b00};
      end else if (inst_valid && inst_ready) begin
        acc_pc.push_back(inst_pc);
        acc_inst.push_back(inst);
        acc_cyc.push_back(cycle);
        mpc = mpc + 64'd4;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reqcyc"}, 64'(bus_reqcyc), 64'h0);
    check({tag, "_req"}, bus_req, 64'h0);
    check({tag, "_valid"}, 64'(inst_valid), 64'h0);
    check({tag, "_inst"}, 64'(inst), 64'h0);
    check({tag, "_inst_pc"}, inst_pc, 64'h0);
  endtask

  task automatic do_reset(input logic [63:0] e);
    reset = 1'b1; entry = e; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    in_burst = 1'b0; inst_ready = 1'b0; redirect_valid = 1'b0;
    step();
    step();
    check_all_zero("reset");
    check("reset_respack", 64'(bus_respack), 64'h0);
    check("reset_reqtag", 64'(bus_reqtag), 64'h0);
    reset = 1'b0;
  endtask

  // Plays the cache: waits for a request, acks after ack_dly cycles, returns
  // 8 beats. Optional redirect before the ack, redirect in a gap after beat
  // redir_beat, or reset asserted on beat rst_beat.
  task automatic serve(input int ack_dly, input int redir_beat, input logic [63:0] rpc,
                       input bit redir_in_req, input int rst_beat,
                       input logic [63:0] rst_entry, output logic [63:0] addr);
    int n = 0;
    while (!bus_reqcyc && n < 40) begin
      step();
      n++;
    end
    check("req_seen", 64'(bus_reqcyc), 64'h1);
    addr = bus_req;
    if (!bus_reqcyc) return;
    for (int i = 0; i < ack_dly; i++) begin
      if (redir_in_req && i == 1) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
      end
      step();
      redirect_valid = 1'b0;
      check("req_hold_cyc", 64'(bus_reqcyc), 64'h1);
      check("req_hold_addr", bus_req, addr);
    end
    bus_reqack = 1'b1;
    step();
    bus_reqack = 1'b0;
    in_burst   = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = beat_data(addr, k);
      if (k == rst_beat) begin
        reset = 1'b1;
        entry = rst_entry;
      end
      step();
      bus_respcyc = 1'b0;
      if (k == rst_beat) begin
        in_burst = 1'b0;
        check_all_zero("midreset");
        return;
      end
      if (k == redir_beat) begin
        redirect_valid = 1'b1;
        redirect_pc    = rpc;
        step();
        redirect_valid = 1'b0;
      end
    end
    in_burst = 1'b0;
  endtask

  task automatic accept_n(input int n);
    int target = acc_pc.size() + n;
    int b = 0;
    inst_ready = 1'b1;
    while (acc_pc.size() < target && b < 60) begin
      step();
      b++;
    end
    inst_ready = 1'b0;
    check("accept_budget", 64'(acc_pc.size() >= target), 64'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] a;
    int base;
    int bad;
    reset = 1'b1; entry = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    bus_resp = '0; bus_resptag = 13'h1abc; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;

    // Full line from 0x1000, ack three cycles after the request.
    do_reset(64'h1000);
    check("idle_cycle_reqcyc", 64'(bus_reqcyc), 64'h0);
    step();
    check("first_reqcyc", 64'(bus_reqcyc), 64'h1);
    serve(3, -1, 64'h0, 1'b0, -1, 64'h0, a);
    check("lineA_addr", a, 64'h1000);
    check("lineA_first_valid", 64'(inst_valid), 64'h1);
    base = acc_pc.size();
    accept_n(16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (acc_pc.size() > base + i && acc_pc[base + i] !== 64'h1000 + 64'(4 * i)) bad++;
    check("lineA_pc_seq_errors", 64'(bad), 64'h0);
    check("lineA_inst0", 64'(acc_inst[base]), 64'h0);
    check("lineA_inst15", 64'(acc_inst[base + 15]), 64'hF);
    check("lineA_back_to_back", 64'(acc_cyc[base + 15] - acc_cyc[base]), 64'd15);
    check("miss_penalty_reqcyc", 64'(bus_reqcyc), 64'h1);
    check("next_line_addr", bus_req, 64'h1040);

    // Mid-line entry, decode stalled for five cycles.
    do_reset(64'h1038);
    step();
    serve(2, -1, 64'h0, 1'b0, -1, 64'h0, a);
    check("lineB_addr", a, 64'h1000);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", 64'(inst_valid), 64'h1);
      check("stall_pc", inst_pc, 64'h1038);
      check("stall_inst", 64'(inst), 64'd14);
    end
    base = acc_pc.size();
    accept_n(2);
    check("lineB_pc0", acc_pc[base], 64'h1038);
    check("lineB_pc1", acc_pc[base + 1], 64'h103C);
    check("lineB_inst1", 64'(acc_inst[base + 1]), 64'd15);
    check("lineB_count", 64'(acc_pc.size() - base), 64'd2);
    check("lineB_next_addr", bus_req, 64'h1040);

    // Redirect to 0x2006 after beat 3: remaining beats drained, refetch 0x2000.
    serve(1, 3, 64'h2006, 1'b0, -1, 64'h0, a);
    check("drain_addr", a, 64'h1040);
    check("drain_no_valid", 64'(inst_valid), 64'h0);
    check("drain_reqcyc", 64'(bus_reqcyc), 64'h1);
    serve(1, -1, 64'h0, 1'b0, -1, 64'h0, a);
    check("redir_line_addr", a, 64'h2000);
    base = acc_pc.size();
    accept_n(3);
    check("redir_first_pc", acc_pc[base], 64'h2004);
    check("redir_first_inst", 64'(acc_inst[base]), 64'h0000_4001);

    // Redirect in EMIT together with an accept at 0x2010.
    check("emit_pc_before", inst_pc, 64'h2010);
    inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h3000;
    step();
    inst_ready = 1'b0; redirect_valid = 1'b0;
    check("emit_redir_valid", 64'(inst_valid), 64'h0);
    check("emit_redir_no_accept", 64'(acc_pc.size() - base), 64'd3);
    check("emit_redir_reqcyc", 64'(bus_reqcyc), 64'h1);
    check("emit_redir_addr", bus_req, 64'h3000);

    // Reset on beat 5 of the 0x3000 burst, new entry 0x5024.
    serve(2, -1, 64'h0, 1'b0, 5, 64'h5024, a);
    check("rst_burst_addr", a, 64'h3000);
    reset = 1'b0;
    step();
    check("post_reset_reqcyc", 64'(bus_reqcyc), 64'h1);
    check("post_reset_addr", bus_req, 64'h5000);

    // Redirect to 0x6008 while the 0x5000 request waits for its ack.
    serve(3, -1, 64'h6008, 1'b1, -1, 64'h0, a);
    check("req_redir_old_addr", a, 64'h5000);
    check("req_redir_no_valid", 64'(inst_valid), 64'h0);
    serve(1, -1, 64'h0, 1'b0, -1, 64'h0, a);
    check("req_redir_new_addr", a, 64'h6000);
    base = acc_pc.size();
    accept_n(1);
    check("req_redir_pc", acc_pc[base], 64'h6008);
    check("req_redir_inst", 64'(acc_inst[base]), 64'h0001_4002);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
